// File: rtl/hlsm_job_sequencer.sv
// hlsm_job_sequencer: queues operand triples in a small FIFO, issues them one
// at a time to a downstream HLSM, captures its results into a single output
// slot, and drops a job with a sticky error if the HLSM never answers.
module hlsm_job_sequencer #(
    parameter int DEPTH = 4,
    parameter int TMO   = 64
) (
    input  logic                      Clk,
    input  logic                      Rst,
    input  logic                      InValid,
    output logic                      InReady,
    input  logic signed [31:0]        InA,
    input  logic signed [31:0]        InB,
    input  logic signed [31:0]        InC,
    output logic                      HStart,
    output logic signed [31:0]        HA,
    output logic signed [31:0]        HB,
    output logic signed [31:0]        HC,
    input  logic                      HDone,
    input  logic signed [31:0]        HZ,
    input  logic signed [31:0]        HX,
    output logic                      OutValid,
    input  logic                      OutReady,
    output logic signed [31:0]        OutZ,
    output logic signed [31:0]        OutX,
    output logic [$clog2(DEPTH):0]    Count,
    output logic                      Busy,
    output logic                      Err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TMO + 1);

    localparam logic [1:0] sIdle  = 2'd0;
    localparam logic [1:0] sIssue = 2'd1;
    localparam logic [1:0] sWait  = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]       count_q, count_d;
    logic [WW-1:0]       wd_q, wd_d;
    logic signed [31:0]  mem_a [DEPTH];
    logic signed [31:0]  mem_b [DEPTH];
    logic signed [31:0]  mem_c [DEPTH];
    logic signed [31:0]  ha_q, hb_q, hc_q;
    logic signed [31:0]  outz_q, outx_q;
    logic                out_valid_q;
    logic                err_q;

    logic push, pop, done_hit, timeout_hit;

    assign InReady     = (count_q < CW'(DEPTH));
    assign push        = InValid && InReady;
    // Issue is blocked while a result is pending, including the cycle it is
    // being consumed, so sIdle re-evaluates only once OutValid is low.
    assign pop         = (state_q == sIdle) && (count_q != '0) && !out_valid_q;
    assign done_hit    = (state_q == sWait) && HDone;
    assign timeout_hit = (state_q == sWait) && !HDone && (wd_q == WW'(TMO - 1));

    assign HStart   = (state_q == sIssue);
    assign Busy     = (state_q != sIdle);
    assign HA       = ha_q;
    assign HB       = hb_q;
    assign HC       = hc_q;
    assign OutValid = out_valid_q;
    assign OutZ     = outz_q;
    assign OutX     = outx_q;
    assign Count    = count_q;
    assign Err      = err_q;

    // Next-state, watchdog and occupancy logic.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        count_d = count_q;
        case (state_q)
            sIdle:  if (pop) state_d = sIssue;
            sIssue: begin
                state_d = sWait;
                wd_d    = '0;
            end
            sWait: begin
                if (done_hit || timeout_hit) begin
                    state_d = sIdle;
                    wd_d    = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            default: state_d = sIdle;
        endcase
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control state, FIFO pointers, issued operands and result slot.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q     <= sIdle;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            wd_q        <= '0;
            ha_q        <= '0;
            hb_q        <= '0;
            hc_q        <= '0;
            out_valid_q <= 1'b0;
            outz_q      <= '0;
            outx_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            count_q <= count_d;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
                ha_q     <= mem_a[rd_ptr_q];
                hb_q     <= mem_b[rd_ptr_q];
                hc_q     <= mem_c[rd_ptr_q];
            end
            if (out_valid_q && OutReady) begin
                out_valid_q <= 1'b0;
            end else if (done_hit) begin
                out_valid_q <= 1'b1;
                outz_q      <= HZ;
                outx_q      <= HX;
            end
            if (timeout_hit) err_q <= 1'b1;
        end
    end

    // Operand storage; contents need no reset since occupancy gates reads.
    always_ff @(posedge Clk) begin
        if (push) begin
            mem_a[wr_ptr_q] <= InA;
            mem_b[wr_ptr_q] <= InB;
            mem_c[wr_ptr_q] <= InC;
        end
    end

endmodule

// File: tb/tb_hlsm_job_sequencer.sv
// tb_hlsm_job_sequencer: directed checks of the job sequencer against a small
// HLSM model (Z = 3*A + C, X = 2*Z, Done 9 cycles after Start).
module tb_hlsm_job_sequencer;

    localparam int DLY = 9;

    logic               Clk = 1'b0;
    logic               Rst = 1'b1;
    logic               InValid = 1'b0;
    logic               InReady;
    logic signed [31:0] InA = '0, InB = '0, InC = '0;
    logic               HStart;
    logic signed [31:0] HA, HB, HC;
    logic               HDone = 1'b0;
    logic signed [31:0] HZ = '0, HX = '0;
    logic               OutValid;
    logic               OutReady = 1'b0;
    logic signed [31:0] OutZ, OutX;
    logic [2:0]         Count;
    logic               Busy, Err;

    logic               model_en = 1'b1;
    logic               inject = 1'b0;
    int                 mcnt = 0;
    int                 starts = 0;
    logic signed [31:0] ma = '0, mc = '0;

    int total = 0;
    int bad = 0;

    hlsm_job_sequencer #(.DEPTH(4), .TMO(64)) dut (
        .Clk(Clk), .Rst(Rst), .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .InC(InC),
        .HStart(HStart), .HA(HA), .HB(HB), .HC(HC),
        .HDone(HDone), .HZ(HZ), .HX(HX),
        .OutValid(OutValid), .OutReady(OutReady), .OutZ(OutZ), .OutX(OutX),
        .Count(Count), .Busy(Busy), .Err(Err)
    );

    always #5 Clk = ~Clk;

    // HLSM model, driven on the falling edge.
    always @(negedge Clk) begin
        if (Rst) begin
            mcnt  = 0;
            HDone = 1'b0;
        end else begin
            HDone = 1'b0;
            if (inject) begin
                HDone = 1'b1;
                HZ    = 32'h5A;
                HX    = 32'hA5;
            end
            if (mcnt > 0) begin
                mcnt = mcnt - 1;
                if (mcnt == 0) begin
                    HDone = 1'b1;
                    HZ    = 3 * ma + mc;
                    HX    = 2 * (3 * ma + mc);
                end
            end
            if (HStart) begin
                starts = starts + 1;
                if (model_en) begin
                    mcnt = DLY;
                    ma   = HA;
                    mc   = HC;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!OutValid && n < 60) begin
            tick();
            n++;
        end
        chk(tag, 32'(OutValid), 1);
    endtask

    task automatic drive(input int a, input int b, input int c);
        InValid = 1'b1;
        InA = a;
        InB = b;
        InC = c;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int pushed;
        logic signed [31:0] z;
        logic signed [31:0] exp_q[$];

        // Reset state
        repeat (3) tick();
        chk("rst_count", 32'(Count), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_outvalid", 32'(OutValid), 0);
        chk("rst_hstart", 32'(HStart), 0);
        chk("rst_ha", HA, 0);
        chk("rst_outz", OutZ, 0);
        chk("rst_err", 32'(Err), 0);
        Rst = 1'b0;
        chk("rst_inready", 32'(InReady), 1);

        // Single job
        base = starts;
        drive(5, 3, 2);
        tick();
        InValid = 1'b0;
        chk("t1_count1", 32'(Count), 1);
        chk("t1_nostart", 32'(HStart), 0);
        tick();
        chk("t1_hstart", 32'(HStart), 1);
        chk("t1_ha", HA, 5);
        chk("t1_hb", HB, 3);
        chk("t1_hc", HC, 2);
        chk("t1_count0", 32'(Count), 0);
        tick();
        chk("t1_hstart_low", 32'(HStart), 0);
        wait_out("t1_outvalid");
        chk("t1_outz", OutZ, 32'h11);
        chk("t1_outx", OutX, 32'h22);
        chk("t1_starts", 32'(starts - base), 1);
        chk("t1_idle", 32'(Busy), 0);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk("t1_consumed", 32'(OutValid), 0);

        // Backpressure
        base = starts;
        for (int i = 0; i < 5; i++) begin
            drive(3 * i + 1, 3 * i + 2, 3 * i + 3);
            chk("t2_inready", 32'(InReady), 1);
            tick();
        end
        chk("t2_full_count", 32'(Count), 4);
        chk("t2_full_ready", 32'(InReady), 0);
        drive(99, 99, 99);
        repeat (2) tick();
        InValid = 1'b0;
        chk("t2_no_push_full", 32'(Count), 4);
        wait_out("t2_out1");
        chk("t2_z1", OutZ, 6);
        chk("t2_x1", OutX, 12);
        repeat (20) tick();
        chk("t2_one_start", 32'(starts - base), 1);
        chk("t2_queued", 32'(Count), 4);
        chk("t2_hold", 32'(OutValid), 1);
        for (int j = 1; j < 5; j++) begin
            OutReady = 1'b1;
            tick();
            OutReady = 1'b0;
            wait_out("t2_outn");
            chk("t2_zn", OutZ, 3 * (3 * j + 1) + (3 * j + 3));
        end

        // Simultaneous push/pop and order across wrap
        drive(20, 1, 2);
        tick();
        drive(21, 1, 3);
        tick();
        InValid = 1'b0;
        chk("t3_count2", 32'(Count), 2);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        chk("t3_cleared", 32'(OutValid), 0);
        chk("t3_no_issue_on_clear", 32'(HStart), 0);
        chk("t3_still_idle", 32'(Busy), 0);
        chk("t3_count_hold", 32'(Count), 2);
        drive(22, 1, 4);
        tick();
        InValid = 1'b0;
        chk("t3_pushpop_count", 32'(Count), 2);
        chk("t3_pushpop_start", 32'(HStart), 1);
        chk("t3_pushpop_ha", HA, 20);
        exp_q.push_back(62);
        exp_q.push_back(66);
        exp_q.push_back(70);
        pushed = 0;
        for (int cyc = 0; cyc < 800 && (pushed < 7 || exp_q.size() > 0); cyc++) begin
            OutReady = 1'b1;
            if (pushed < 7 && InReady) begin
                drive(23 + pushed, 1, 5 + pushed);
                exp_q.push_back(3 * (23 + pushed) + 5 + pushed);
                pushed++;
            end else begin
                InValid = 1'b0;
            end
            if (OutValid) begin
                if (exp_q.size() == 0) begin
                    chk("t3_extra_out", 32'(OutValid), 0);
                end else begin
                    z = exp_q.pop_front();
                    chk("t3_order_z", OutZ, z);
                    chk("t3_order_x", OutX, 2 * z);
                end
            end
            tick();
        end
        InValid = 1'b0;
        OutReady = 1'b0;
        chk("t3_drained", 32'(exp_q.size()), 0);
        chk("t3_all_pushed", 32'(pushed), 7);

        // Watchdog timeout
        model_en = 1'b0;
        drive(9, 9, 9);
        tick();
        drive(2, 0, 1);
        tick();
        InValid = 1'b0;
        chk("t4_hstart", 32'(HStart), 1);
        chk("t4_ha", HA, 9);
        tick();
        chk("t4_err_early", 32'(Err), 0);
        repeat (63) tick();
        chk("t4_err_63", 32'(Err), 0);
        chk("t4_busy_63", 32'(Busy), 1);
        tick();
        chk("t4_err_64", 32'(Err), 1);
        chk("t4_idle", 32'(Busy), 0);
        chk("t4_no_out", 32'(OutValid), 0);
        chk("t4_queued", 32'(Count), 1);
        model_en = 1'b1;
        wait_out("t4_next_out");
        chk("t4_next_z", OutZ, 7);
        chk("t4_next_x", OutX, 14);
        chk("t4_err_sticky", 32'(Err), 1);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // Reset mid-job
        drive(3, 0, 0);
        tick();
        drive(4, 0, 0);
        tick();
        chk("t5_hstart", 32'(HStart), 1);
        drive(5, 0, 0);
        tick();
        InValid = 1'b0;
        chk("t5_count2", 32'(Count), 2);
        tick();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        chk("t5_count", 32'(Count), 0);
        chk("t5_busy", 32'(Busy), 0);
        chk("t5_outvalid", 32'(OutValid), 0);
        chk("t5_err_cleared", 32'(Err), 0);
        chk("t5_ha", HA, 0);
        chk("t5_inready", 32'(InReady), 1);
        inject = 1'b1;
        tick();
        inject = 1'b0;
        repeat (3) tick();
        chk("t5_stale_done", 32'(OutValid), 0);
        chk("t5_stale_outz", OutZ, 0);
        chk("t5_stale_busy", 32'(Busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hlsm_job_sequencer.md
HLSM_JOB_SEQUENCER -- requirements
Module: hlsm_job_sequencer

Interface
REQ-001 Parameter DEPTH, default 4, operand FIFO depth in entries (power of two, 2..16).
REQ-002 Parameter TMO, default 64, watchdog limit in cycles for a Done response.
REQ-003 Clk  in  1  single clock, all state updates on rising edge.
REQ-004 Rst  in  1  synchronous, active-high reset.
REQ-005 InValid  in  1  operand triple offered.
REQ-006 InReady  out  1  FIFO can accept; equals (Count < DEPTH), combinational from Count.
REQ-007 InA, InB, InC  in  32 signed  operand triple.
REQ-008 HStart  out  1  start pulse to the downstream HLSM.
REQ-009 HA, HB, HC  out  32 signed  operands driven to the HLSM.
REQ-010 HDone  in  1  HLSM completion pulse.
REQ-011 HZ, HX  in  32 signed  HLSM results, valid while HDone=1.
REQ-012 OutValid  out  1  result slot full.
REQ-013 OutReady  in  1  consumer accepts result.
REQ-014 OutZ, OutX  out  32 signed  captured results.
REQ-015 Count  out  $clog2(DEPTH)+1  FIFO occupancy.
REQ-016 Busy  out  1  high whenever the FSM is not in sIdle.
REQ-017 Err  out  1  sticky watchdog-timeout flag.

Function
REQ-018 The FIFO SHALL push {InA,InB,InC} on a cycle where InValid=1 and InReady=1; no push when full, no bypass path.
REQ-019 The FSM SHALL have exactly three states: sIdle, sIssue, sWait.
REQ-020 sIdle -> sIssue when Count>0 and OutValid=0; the head entry pops into HA/HB/HC on that edge.
REQ-021 Same-cycle push and pop SHALL leave Count unchanged; push-only adds 1; pop-only subtracts 1; FIFO pointers wrap modulo DEPTH.
REQ-022 HStart SHALL be 1 for exactly the one cycle the FSM occupies sIssue and 0 otherwise; sIssue -> sWait unconditionally.
REQ-023 HA/HB/HC SHALL hold stable from sIssue until the next pop.
REQ-024 In sWait, HDone=1 SHALL capture HZ->OutZ and HX->OutX, set OutValid, clear the watchdog counter, and return to sIdle.
REQ-025 In sWait, the watchdog SHALL count cycles; on reaching TMO without HDone it SHALL set Err, leave OutValid unchanged, and return to sIdle; the job is dropped.
REQ-026 HDone outside sWait SHALL be ignored.
REQ-027 OutValid SHALL clear on the edge where OutValid=1 and OutReady=1; OutZ/OutX SHALL hold while OutValid=1.
REQ-028 A new issue SHALL NOT start in the cycle OutValid clears; sIdle re-evaluates on the following cycle.
REQ-029 Latency: an operand pushed into an empty FIFO while idle with OutValid=0 at edge N SHALL produce HStart high in cycle N+1..N+2 (sIssue entered at edge N+1); OutValid rises on the edge that samples HDone=1.

Reset
REQ-030 While Rst=1: state=sIdle, FIFO emptied (Count=0), HStart=0, HA/HB/HC=0, OutValid=0, OutZ/OutX=0, Err=0, watchdog=0.
REQ-031 Rst mid-job SHALL discard the in-flight job and all queued entries; the downstream HLSM shares the same Rst.
REQ-032 InReady SHALL be 1 in the first cycle after Rst deasserts.

Verification
REQ-033 Single job: push (5,3,2) into idle block with an HLSM model returning Z=0x11, X=0x22 with Done 9 cycles after Start -> one HStart pulse, HA/HB/HC=5/3/2, OutValid=1 with OutZ=0x11, OutX=0x22.
REQ-034 Backpressure: hold OutReady=0, push 5 triples with DEPTH=4 -> one job completes, 4 remain queued, InReady=0 at Count=4, no second HStart until OutValid is consumed.
REQ-035 Simultaneous push/pop: Count=2, push during the sIdle->sIssue edge -> Count stays 2; FIFO order preserved across pointer wrap after 10 jobs.
REQ-036 Timeout: model never asserts Done -> Err=1 exactly TMO=64 cycles after entering sWait, OutValid stays 0, next queued job issues normally, Err stays 1.
REQ-037 Reset mid-job: assert Rst 3 cycles after HStart with Count=2 -> Count=0, Busy=0, OutValid=0, and a stale HDone after reset produces no output.
